// File: rtl/td4_disp_pkg.sv
// Shared display definitions for the TD4 board: segment width, blank pattern,
// slot state type and the active-high hex-to-segment font.
package td4_disp_pkg;

    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        SLOT_BLANK,
        SLOT_SHOW
    } slot_state_e;

    // Segment order is gfedcba, bit 0 = a, 1 = lit.
    function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] nib);
        logic [SEG_W-1:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b1111100;
            4'hC: seg = 7'b0111001;
            4'hD: seg = 7'b1011110;
            4'hE: seg = 7'b1111001;
            4'hF: seg = 7'b1110001;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus between the value source and the scan driver: packed digits in,
// multiplexed segment/digit drive out.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    import td4_disp_pkg::*;

    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [SEG_W-1:0]        seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   digit_out;
    logic                    frame_done;

    modport master (
        output value_in, dp_in, digit_en,
        input  seg_out, dp_out, digit_out, frame_done
    );

    modport slave (
        input  value_in, dp_in, digit_en,
        output seg_out, dp_out, digit_out, frame_done
    );

endinterface

// File: rtl/seg7_slot_timer.sv
// Digit slot sequencer: slot counter, digit index, blank/show slot state and
// the frame wrap strobe on the last cycle of the last digit.
module seg7_slot_timer
    import td4_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 8250,
    parameter int BLANK_CYCLES = 32,
    parameter int CNT_W        = 14,
    parameter int IDX_W        = 2
) (
    input  logic             clk_in,
    input  logic             reset_n,
    output logic [IDX_W-1:0] idx,
    output logic             in_show,
    output logic             frame_wrap
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam slot_state_e      SLOT_START = (BLANK_CYCLES > 0) ? SLOT_BLANK : SLOT_SHOW;

    logic [CNT_W-1:0] cnt;
    logic             slot_end;
    slot_state_e      state;

    assign slot_end   = (cnt == CNT_LAST);
    assign frame_wrap = slot_end && (idx == IDX_LAST);
    assign in_show    = (state == SLOT_SHOW);

    // state always matches the blank/show decode of cnt; it is updated from
    // the value cnt is about to take so that it needs no extra cycle.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            idx   <= '0;
            state <= SLOT_START;
        end else if (slot_end) begin
            cnt   <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            state <= SLOT_START;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= ((cnt + CNT_W'(1)) >= CNT_BLANK) ? SLOT_SHOW : SLOT_BLANK;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: snapshots the packed hex value once
// per frame and drives one digit per slot with a leading blanking interval.
module seg7_scan_driver
    import td4_disp_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 8250,
    parameter int BLANK_CYCLES     = 32,
    parameter int SEG_ACTIVE_LOW   = 1,
    parameter int DIGIT_ACTIVE_LOW = 1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    seg7_scan_driver_if.slave disp
);

    localparam int CNT_W = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
    localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);

    // Off levels double as XOR masks that turn the active-high form into pin polarity.
    localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
    localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIGIT_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                        : {NUM_DIGITS{1'b0}};

    logic [IDX_W-1:0]        idx;
    logic                    in_show;
    logic                    frame_wrap;
    logic [4*NUM_DIGITS-1:0] snap_val;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_en;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   cur_sel;
    logic                    lit;

    logic [SEG_W-1:0]        seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   digit_q;
    logic                    frame_done_q;

    seg7_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .CNT_W       (CNT_W),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .idx       (idx),
        .in_show   (in_show),
        .frame_wrap(frame_wrap)
    );

    assign cur_nib = snap_val[idx*4 +: 4];
    assign cur_sel = NUM_DIGITS'(1) << idx;
    assign lit     = in_show && snap_en[idx];

    // NOTE: non-blocking assignments let the output mux below read the
    // snapshot of the frame in flight even on the wrap cycle that reloads it.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            snap_val     <= '0;
            snap_dp      <= '0;
            snap_en      <= '0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            digit_q      <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            if (frame_wrap) begin
                snap_val <= disp.value_in;
                snap_dp  <= disp.dp_in;
                snap_en  <= disp.digit_en;
            end
            frame_done_q <= frame_wrap;
            if (lit) begin
                seg_q   <= seg7_encode(cur_nib) ^ SEG_OFF;
                dp_q    <= snap_dp[idx] ^ DP_OFF;
                digit_q <= cur_sel ^ DIG_OFF;
            end else begin
                seg_q   <= SEG_OFF;
                dp_q    <= DP_OFF;
                digit_q <= DIG_OFF;
            end
        end
    end

    assign disp.seg_out    = seg_q;
    assign disp.dp_out     = dp_q;
    assign disp.digit_out  = digit_q;
    assign disp.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a frame-position model compared every cycle,
// plus directed checks with hand-derived segment patterns and timings.
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    // Active-high font gfedcba straight from the display table.
    localparam logic [6:0] FONT [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    seg7_scan_driver_if #(.NUM_DIGITS(ND)) disp_if ();

    seg7_scan_driver #(
        .NUM_DIGITS      (ND),
        .SCAN_DIV        (SD),
        .BLANK_CYCLES    (BC),
        .SEG_ACTIVE_LOW  (1),
        .DIGIT_ACTIVE_LOW(1)
    ) dut (
        .clk_in (clk),
        .reset_n(reset_n),
        .disp   (disp_if.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: edge k after reset release shows frame position k mod FRAME,
    // using inputs sampled at the last edge of the previous frame.
    initial begin : model
        int unsigned      k;
        int               p, cnt, idx;
        bit               show;
        logic [4*ND-1:0]  m_val;
        logic [ND-1:0]    m_dp, m_en;
        logic [ND-1:0]    exp_digit;
        logic [6:0]       exp_seg;
        logic             exp_dp, exp_fd;
        k = 0; m_val = '0; m_dp = '0; m_en = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                k = 0; m_val = '0; m_dp = '0; m_en = '0;
                #1;
                check("rst_digit", 32'(disp_if.digit_out), 32'hF);
                check("rst_seg", 32'(disp_if.seg_out), 32'h7F);
                check("rst_dp", 32'(disp_if.dp_out), 32'h1);
                check("rst_fd", 32'(disp_if.frame_done), 32'h0);
            end else begin
                p    = int'(k % FRAME);
                cnt  = p % SD;
                idx  = p / SD;
                show = (cnt >= BC) && m_en[idx];
                exp_digit = show ? ~(ND'(1) << idx) : {ND{1'b1}};
                exp_seg   = show ? ~FONT[(m_val >> (4 * idx)) & 16'hF] : 7'h7F;
                exp_dp    = show ? ~m_dp[idx] : 1'b1;
                exp_fd    = (p == FRAME - 1);
                if (p == FRAME - 1) begin
                    m_val = disp_if.value_in;
                    m_dp  = disp_if.dp_in;
                    m_en  = disp_if.digit_en;
                end
                k++;
                #1;
                check("model_digit", 32'(disp_if.digit_out), 32'(exp_digit));
                check("model_seg", 32'(disp_if.seg_out), 32'(exp_seg));
                check("model_dp", 32'(disp_if.dp_out), 32'(exp_dp));
                check("model_fd", 32'(disp_if.frame_done), 32'(exp_fd));
            end
        end
    end

    task automatic wait_digit(input logic [ND-1:0] pat, input string name);
        int n = 0;
        @(negedge clk);
        while (disp_if.digit_out !== pat && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check({name, "_found"}, 32'(disp_if.digit_out), 32'(pat));
    endtask

    // Release reset at a falling edge and count samples to the first lit digit.
    task automatic release_and_time(input string name);
        int n = 0;
        reset_n = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (disp_if.digit_out === 4'hF && n < 3 * FRAME);
        check(name, 32'(n), 32'(FRAME + BC + 1));
    endtask

    initial begin : stim
        int fd_cnt, bad_hot, dp_lo, dp_lo_d0, odd_on;
        int on_cnt [ND];
        int n;

        disp_if.value_in = 16'h1234;
        disp_if.digit_en = 4'hF;
        disp_if.dp_in    = 4'h0;

        // 1: reset levels, then a fully blank first frame
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t1_digit", 32'(disp_if.digit_out), 32'hF);
        check("t1_seg", 32'(disp_if.seg_out), 32'h7F);
        check("t1_dp", 32'(disp_if.dp_out), 32'h1);
        check("t1_fd", 32'(disp_if.frame_done), 32'h0);
        release_and_time("t1_first_show");

        // 2: second frame shows digit 0 = "4" first, later digit 3 = "1"
        check("t2_d0_digit", 32'(disp_if.digit_out), 32'b1110);
        check("t2_d0_seg", 32'(disp_if.seg_out), 32'b0011001);
        wait_digit(4'b0111, "t2_d3");
        check("t2_d3_seg", 32'(disp_if.seg_out), 32'b1111001);

        // 3: steady scan over two whole frame periods
        fd_cnt = 0; bad_hot = 0;
        for (int d = 0; d < ND; d++) on_cnt[d] = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (disp_if.frame_done) fd_cnt++;
            if ($countones(~disp_if.digit_out) > 1) bad_hot++;
            for (int d = 0; d < ND; d++)
                if (!disp_if.digit_out[d]) on_cnt[d]++;
        end
        check("t3_frame_done", 32'(fd_cnt), 32'd2);
        check("t3_one_hot", 32'(bad_hot), 32'd0);
        for (int d = 0; d < ND; d++)
            check("t3_on_cycles", 32'(on_cnt[d]), 32'(2 * (SD - BC)));

        // 4: value changes during digit 1; rest of frame keeps old value
        wait_digit(4'b1101, "t4_d1");
        disp_if.value_in = 16'hABCD;
        wait_digit(4'b1011, "t4_d2_old");
        check("t4_d2_old_seg", 32'(disp_if.seg_out), 32'b0100100);
        wait_digit(4'b0111, "t4_d3_old");
        check("t4_d3_old_seg", 32'(disp_if.seg_out), 32'b1111001);
        wait_digit(4'b1110, "t4_d0_new");
        check("t4_d0_new_seg", 32'(disp_if.seg_out), 32'b0100001);
        wait_digit(4'b1101, "t4_d1_new");
        check("t4_d1_new_seg", 32'(disp_if.seg_out), 32'b1000110);
        wait_digit(4'b1011, "t4_d2_new");
        check("t4_d2_new_seg", 32'(disp_if.seg_out), 32'b0000011);
        wait_digit(4'b0111, "t4_d3_new");
        check("t4_d3_new_seg", 32'(disp_if.seg_out), 32'b0001000);

        // 5: digits 1 and 3 disabled, decimal point on digit 0 only
        disp_if.digit_en = 4'b0101;
        disp_if.dp_in    = 4'b0001;
        n = 0;
        @(negedge clk);
        while (!disp_if.frame_done && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("t5_wrap_found", 32'(disp_if.frame_done), 32'h1);
        dp_lo = 0; dp_lo_d0 = 0; odd_on = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (!disp_if.dp_out) dp_lo++;
            if (!disp_if.dp_out && disp_if.digit_out == 4'b1110) dp_lo_d0++;
            if (!disp_if.digit_out[1] || !disp_if.digit_out[3]) odd_on++;
        end
        check("t5_odd_digits", 32'(odd_on), 32'd0);
        check("t5_dp_total", 32'(dp_lo), 32'(SD - BC));
        check("t5_dp_digit0", 32'(dp_lo_d0), 32'(SD - BC));

        // 6: asynchronous reset in the middle of digit 2 SHOW
        wait_digit(4'b1011, "t6_d2");
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("t6_digit", 32'(disp_if.digit_out), 32'hF);
        check("t6_seg", 32'(disp_if.seg_out), 32'h7F);
        check("t6_dp", 32'(disp_if.dp_out), 32'h1);
        check("t6_fd", 32'(disp_if.frame_done), 32'h0);
        repeat (3) @(negedge clk);
        release_and_time("t6_first_show");
        check("t6_restart_digit", 32'(disp_if.digit_out), 32'b1110);
        check("t6_restart_seg", 32'(disp_if.seg_out), 32'b0100001);
        check("t6_restart_dp", 32'(disp_if.dp_out), 32'h0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
